// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit common-anode 7-segment driver with
// per-frame shadow registers, guard blanking and digit blink. Option: SEG_LZ_BLANK_EN.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 2,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic [3:0]  blink_mask,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_sh_digits;
    logic [3:0]    r_sh_dp;
    logic [3:0]    r_sh_blink;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;
    logic [7:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_frame_tick;

    logic          w_cnt_wrap;
    logic          w_load;
    logic          w_guard;
    logic [3:0]    w_digit;
    logic [7:0]    w_seg;
    logic [3:0]    w_an;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_cnt_wrap = (r_cnt == CNT_MAX);
    assign w_load     = w_cnt_wrap && (r_idx == 2'd3);
    assign w_guard    = (r_cnt < CNT_GUARD);
    assign w_digit    = r_sh_digits[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Inputs are sampled only at the frame boundary so a digit never tears mid-scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blink  <= '0;
        end else if (w_load) begin
            r_sh_digits <= digits;
            r_sh_dp     <= dp;
            r_sh_blink  <= blink_mask;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [3:0] r_sh_lzb;
    logic [3:0] w_lzb;

    always_comb begin
        w_lzb    = '0;
        w_lzb[3] = (digits[15:12] == 4'd0);
        w_lzb[2] = (digits[11:8] == 4'd0) && w_lzb[3];
        w_lzb[1] = (digits[7:4] == 4'd0) && w_lzb[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_lzb <= '0;
        end else if (w_load) begin
            r_sh_lzb <= w_lzb;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (r_bcnt == BLINK_MAX) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    always_comb begin
        w_an  = 4'b1111;
        w_seg = 8'hFF;
        if (!w_guard) begin
            w_an  = ~(4'b0001 << r_idx);
            w_seg = {~r_sh_dp[r_idx], f_decode(w_digit)};
`ifdef SEG_LZ_BLANK_EN
            if (r_sh_lzb[r_idx]) begin
                w_seg[6:0] = 7'h7F;
            end
`endif
            if (!r_phase && r_sh_blink[r_idx]) begin
                w_seg = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= 4'b1111;
            r_seg        <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_frame_tick <= w_load;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (REFRESH_DIV=8, GUARD=2, BLINK_DIV=64).
module tb_seg_scan_driver;
    localparam int RD = 8;
    localparam int G  = 2;
    localparam int FR = 4 * RD;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int n_run;
    int n_fail;
    int ecnt;

    seg_scan_driver #(
        .REFRESH_DIV(RD),
        .GUARD      (G),
        .BLINK_DIV  (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    (digits),
        .dp        (dp),
        .blink_mask(blink_mask),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge k (1-based since reset release) shows the cnt/idx state before edge k.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        ecnt++;
    endtask

    function automatic bit in_guard(int k);
        return ((k - 1) % RD) < G;
    endfunction

    function automatic int slot_of(int k);
        return ((k - 1) / RD) % 4;
    endfunction

    function automatic logic [3:0] exp_an(int k);
        logic [3:0] one;
        one = 4'b0001;
        if (in_guard(k)) return 4'b1111;
        return ~(one << slot_of(k));
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        digits     = 16'h1234;
        dp         = 4'b0100;
        blink_mask = 4'b0000;
        repeat (3) @(negedge clk);
        n_run++;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an an=%b exp=1111", an); end
        n_run++;
        if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg seg=%h exp=ff", seg); end
        n_run++;
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ft ft=%b exp=0", frame_tick); end
        rst_n = 1'b1;
        ecnt  = 0;
        for (int k = 1; k <= RD; k++) begin
            tick();
            n_run++;
            if (an !== ((k >= 3) ? 4'b1110 : 4'b1111)) begin
                n_fail++; $display("FAIL slot0_an k=%0d an=%b", ecnt, an);
            end
            n_run++;
            if (seg !== ((k >= 3) ? 8'hC0 : 8'hFF)) begin
                n_fail++; $display("FAIL slot0_seg k=%0d seg=%h", ecnt, seg);
            end
        end
    endtask

    task automatic test_digits_1234();
        logic [7:0] tab [4];
        logic [7:0] es;
        for (int k = RD + 1; k <= 2 * FR; k++) begin
            tick();
            if (ecnt <= FR) tab = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
            else            tab = '{8'h99, 8'hB0, 8'h24, 8'hF9};
            es = in_guard(ecnt) ? 8'hFF : tab[slot_of(ecnt)];
            n_run++;
            if (an !== exp_an(ecnt)) begin
                n_fail++; $display("FAIL d1234_an k=%0d an=%b exp=%b", ecnt, an, exp_an(ecnt));
            end
            n_run++;
            if (seg !== es) begin
                n_fail++; $display("FAIL d1234_seg k=%0d seg=%h exp=%h", ecnt, seg, es);
            end
            n_run++;
            if (frame_tick !== ((ecnt % FR) == 0)) begin
                n_fail++; $display("FAIL d1234_ft k=%0d ft=%b", ecnt, frame_tick);
            end
        end
    endtask

    task automatic test_mid_frame_change();
        logic [7:0] tab [4];
        logic [7:0] es;
        for (int k = 2 * FR + 1; k <= 4 * FR; k++) begin
            tick();
            if (ecnt == 75)  digits = 16'h5678;
            if (ecnt == 100) blink_mask = 4'b0011;
            if (ecnt <= 3 * FR) tab = '{8'h99, 8'hB0, 8'h24, 8'hF9};
            else                tab = '{8'h80, 8'hF8, 8'h02, 8'h92};
            es = in_guard(ecnt) ? 8'hFF : tab[slot_of(ecnt)];
            n_run++;
            if (an !== exp_an(ecnt)) begin
                n_fail++; $display("FAIL midchg_an k=%0d an=%b exp=%b", ecnt, an, exp_an(ecnt));
            end
            n_run++;
            if (seg !== es) begin
                n_fail++; $display("FAIL midchg_seg k=%0d seg=%h exp=%h", ecnt, seg, es);
            end
            n_run++;
            if (frame_tick !== ((ecnt % FR) == 0)) begin
                n_fail++; $display("FAIL midchg_ft k=%0d ft=%b", ecnt, frame_tick);
            end
        end
    endtask

    // phase seen at edge k is visible while ((k-1)/64) is even.
    task automatic test_blink();
        logic [7:0] tab [4];
        logic [7:0] es;
        bit         vis;
        tab = '{8'h80, 8'hF8, 8'h02, 8'h92};
        for (int k = 4 * FR + 1; k <= 7 * FR; k++) begin
            tick();
            vis = (((ecnt - 1) / 64) % 2) == 0;
            if (in_guard(ecnt))                       es = 8'hFF;
            else if (!vis && (slot_of(ecnt) < 2))     es = 8'hFF;
            else                                      es = tab[slot_of(ecnt)];
            n_run++;
            if (an !== exp_an(ecnt)) begin
                n_fail++; $display("FAIL blink_an k=%0d an=%b exp=%b", ecnt, an, exp_an(ecnt));
            end
            n_run++;
            if (seg !== es) begin
                n_fail++; $display("FAIL blink_seg k=%0d seg=%h exp=%h", ecnt, seg, es);
            end
        end
    endtask

    task automatic test_code_blank();
        logic [7:0] tab [4];
        logic [7:0] es;
        digits     = 16'h00A7;
        dp         = 4'b0000;
        blink_mask = 4'b0000;
        for (int k = 7 * FR + 1; k <= 10 * FR; k++) begin
            tick();
            if (ecnt == 260) digits = 16'h0050;
`ifdef SEG_LZ_BLANK_EN
            if (ecnt <= 9 * FR) tab = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
            else                tab = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
            if (ecnt <= 9 * FR) tab = '{8'hF8, 8'hFF, 8'hC0, 8'hC0};
            else                tab = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
            n_run++;
            if (an !== exp_an(ecnt)) begin
                n_fail++; $display("FAIL code_an k=%0d an=%b exp=%b", ecnt, an, exp_an(ecnt));
            end
            if (ecnt > 8 * FR) begin
                es = in_guard(ecnt) ? 8'hFF : tab[slot_of(ecnt)];
                n_run++;
                if (seg !== es) begin
                    n_fail++; $display("FAIL code_seg k=%0d seg=%h exp=%h", ecnt, seg, es);
                end
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        logic [7:0] es;
        for (int k = 10 * FR + 1; k <= 10 * FR + 20; k++) tick();
        rst_n = 1'b0;
        #1;
        n_run++;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL async_rst_an an=%b exp=1111", an); end
        n_run++;
        if (seg !== 8'hFF) begin n_fail++; $display("FAIL async_rst_seg seg=%h exp=ff", seg); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_run++;
            if (an !== 4'b1111 || seg !== 8'hFF) begin
                n_fail++; $display("FAIL rst_hold c=%0d an=%b seg=%h", c, an, seg);
            end
        end
        rst_n = 1'b1;
        ecnt  = 0;
        for (int k = 1; k <= FR; k++) begin
            tick();
            es = in_guard(ecnt) ? 8'hFF : 8'hC0;
            n_run++;
            if (an !== exp_an(ecnt)) begin
                n_fail++; $display("FAIL rst_restart_an k=%0d an=%b exp=%b", ecnt, an, exp_an(ecnt));
            end
            n_run++;
            if (seg !== es) begin
                n_fail++; $display("FAIL rst_restart_seg k=%0d seg=%h exp=%h", ecnt, seg, es);
            end
            n_run++;
            if (frame_tick !== (ecnt == FR)) begin
                n_fail++; $display("FAIL rst_restart_ft k=%0d ft=%b", ecnt, frame_tick);
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        ecnt   = 0;
        test_reset();
        test_digits_1234();
        test_mid_frame_change();
        test_blink();
        test_code_blank();
        test_reset_mid_slot();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Downstream display stage for the stopwatch: takes four BCD digits, decimal-point bits and a blink mask from the time-keeping core, and time-multiplexes them onto the board's four common-anode seven-segment digits via `seg`/`an`. It double-buffers the digit values per frame so digits never tear mid-scan, inserts a blanking guard between slots against ghosting, and blinks selected digits to indicate the field being adjusted.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz/slot at 100 MHz); legal range ≥ `GUARD`+2.
- `GUARD`, 2: blank cycles at the start of each slot (`an` all high).
- `BLINK_DIV`, 25000000: clock cycles per blink half-period.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `digits` in 16: BCD digits; `[3:0]` rightmost (`an[0]`), `[15:12]` leftmost (`an[3]`).
- `dp` in 4: decimal point per digit, 1 = lit.
- `blink_mask` in 4: 1 = the digit blinks.
- `seg` out 8: active-low segments; `[0]`=a … `[6]`=g, `[7]`=dp.
- `an` out 4: active-low digit enables, at most one low.
- `frame_tick` out 1: one-cycle pulse per completed 4-digit frame.

## Operation
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1 and wraps. On wrap, digit index `idx` advances 0→1→2→3→0.
- Shadow registers for `digits`/`dp`/`blink_mask` load on the edge where `cnt` wraps with `idx`=3, i.e. as `idx` returns to 0. Inputs are sampled only there. Mid-frame input changes are ignored until the next frame.
- Slot output:
  - `cnt` < `GUARD`: `an`=4'b1111, `seg`=8'hFF.
  - Otherwise: `an` = one-hot low at bit `idx`, `seg` = decode of shadow digit `idx`.
- Decode, with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex). Codes 10–15 give `seg[6:0]`=7'h7F (blank).
- `seg[7]` = ~shadow `dp[idx]`.
- Blink:
  - Counter 0..`BLINK_DIV`-1 toggles `phase` on wrap. Reset value is `phase`=1 (visible).
  - When `phase`=0 and shadow `blink_mask[idx]`=1, `seg`=8'hFF while `an` is still driven.
  - The blink counter is free-running and independent of the scan.
- `frame_tick` = 1 for exactly the cycle after each shadow load.
- Reset values:
  - `cnt`=0, `idx`=0, shadows=0, `phase`=1, blink counter=0.
  - Outputs: `an`=4'b1111, `seg`=8'hFF, `frame_tick`=0.
  - Reset mid-slot takes effect immediately (asynchronous). Scanning restarts at slot 0 with the guard.
- Until the first shadow load, shadow digits are 0, so the first frame after reset shows "0000" with no dp.

## Timing
- `an`, `seg` and `frame_tick` are registered. They reflect the `cnt`/`idx`/`phase` values of the previous cycle, giving a fixed 1-cycle lag.
- Scan timing, counting the first rising edge with `rst_n` high as edge 1:
  - Slot 0: `an` low for `REFRESH_DIV`-`GUARD` cycles.
  - Full frame: 4·`REFRESH_DIV` cycles.
  - `frame_tick` period: 4·`REFRESH_DIV` cycles. The first pulse comes one cycle after edge 4·`REFRESH_DIV`.
- Input-to-display latency: up to 4·`REFRESH_DIV`+2 cycles. This is a wait for the frame boundary, plus the shadow load, plus the output register.
- Simultaneous blink-phase change and slot change: both apply on the same output update. No extra blank cycle is inserted.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking on the shadow digits.
  - Digit 3 blanks if it is 0.
  - Digit 2 blanks if it is 0 and digit 3 is blank.
  - Digit 1 blanks likewise.
  - Digit 0 never blanks.
  - The blank is computed at shadow load.
  - A blanked digit still shows its dp, and `an` is still driven.
- Undefined: every digit is decoded as-is. Zero blanking logic is compiled out.

## Test plan
- Reset hold, `REFRESH_DIV`=8, `GUARD`=2 → while `rst_n`=0: `an`=1111, `seg`=FF. After release, frame 0 shows "0000": `an`=1110 with `seg`=C0 in cycles 3–8.
- `digits`=16'h1234, `dp`=4'b0100, all else 0 → second frame shows the following, with `frame_tick` pulsing every 32 cycles:
  - `an`=1110, `seg`=99
  - `an`=1101, `seg`=B0
  - `an`=1011, `seg`=24 (dp lit)
  - `an`=0111, `seg`=F9
- Change `digits` 16'h1234→16'h5678 during slot 1 → the rest of the current frame still shows 1234. The next frame shows 5678.
- `blink_mask`=4'b0011, `BLINK_DIV`=64 → digits 0/1 show `seg`=FF while `phase`=0 and normal codes while `phase`=1. Digits 2/3 are never blanked.
- `digits`=16'h00A7 → digit 1 shows `seg`=FF (code 10 blank).
  - With `SEG_LZ_BLANK_EN` and `digits`=16'h0050: digits 3/2 show FF, digit 1 shows 92, digit 0 shows C0.
  - Without the macro, digits 3/2 show C0.
- Assert `rst_n`=0 mid-slot 2 for 3 cycles → `an`/`seg` go to 1111/FF asynchronously. After release, the scan restarts at slot 0 with the guard, and the shadows show "0000".
